comparator_seq_ctrl: RTL and testbench

//  Sequencer that drives an external 4-bit combinational comparator (ports Eq/Gt/Sm) and

---
 rtl/comparator_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq_ctrl.sv
// Nibble-serial magnitude compare sequencer driving one external 4-bit comparator.
// Walks MSB nibble first and stops at the first unequal nibble or on bad comparator flags.
module comparator_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic [3:0]           cmp_a,
  output logic [3:0]           cmp_b,
  input  logic                 cmp_eq,
  input  logic                 cmp_gt,
  input  logic                 cmp_sm,
  output logic                 busy,
  output logic                 done,
  output logic                 eq,
  output logic                 gt,
  output logic                 sm,
  output logic                 err
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_reg, a_nxt;
  logic [W-1:0]     b_reg, b_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_dec;
  logic [3:0]       cmp_a_nxt, cmp_b_nxt;
  logic             busy_nxt, done_nxt;
  logic             eq_nxt, gt_nxt, sm_nxt, err_nxt;
  logic             flags_ok;

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    idx_nxt   = idx;
    idx_dec   = idx - IDX_W'(1);
    cmp_a_nxt = cmp_a;
    cmp_b_nxt = cmp_b;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    eq_nxt    = eq;
    gt_nxt    = gt;
    sm_nxt    = sm;
    err_nxt   = err;
    flags_ok  = ({cmp_eq, cmp_gt, cmp_sm} == 3'b100) ||
                ({cmp_eq, cmp_gt, cmp_sm} == 3'b010) ||
                ({cmp_eq, cmp_gt, cmp_sm} == 3'b001);

    case (state)
      S_IDLE: begin
        if (start) begin
          a_nxt     = a;
          b_nxt     = b;
          idx_nxt   = IDX_TOP;
          // Present the MSB nibble straight from the capture so RUN starts comparing at once
          cmp_a_nxt = a[W-1 -: 4];
          cmp_b_nxt = b[W-1 -: 4];
          eq_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          sm_nxt    = 1'b0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!flags_ok) begin
          err_nxt   = 1'b1;
          eq_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          sm_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (cmp_gt) begin
          gt_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (cmp_sm) begin
          sm_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (idx == '0) begin
          eq_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx_dec;
          cmp_a_nxt = a_reg[{idx_dec, 2'b00} +: 4];
          cmp_b_nxt = b_reg[{idx_dec, 2'b00} +: 4];
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      sm    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      a_reg <= a_nxt;
      b_reg <= b_nxt;
      idx   <= idx_nxt;
      cmp_a <= cmp_a_nxt;
      cmp_b <= cmp_b_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      eq    <= eq_nxt;
      gt    <= gt_nxt;
      sm    <= sm_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Bench for comparator_seq_ctrl (NIBBLES=4) with a behavioural 4-bit comparator and
// an expected-result queue filled at start and drained when done pulses.
module tb_comparator_seq_ctrl;

  typedef struct {
    logic [3:0] res;  // {eq, gt, sm, err}
    int         lat;  // cycle after the accepting edge in which done is high
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_eq, cmp_gt, cmp_sm;
  logic        busy, done, eq, gt, sm, err;
  logic        force_en = 1'b0;
  logic [2:0]  force_flags = 3'b000;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  logic [7:0] pairs[$];

  always #5 clk = ~clk;

  assign cmp_eq = force_en ? force_flags[2] : (cmp_a == cmp_b);
  assign cmp_gt = force_en ? force_flags[1] : (cmp_a >  cmp_b);
  assign cmp_sm = force_en ? force_flags[0] : (cmp_a <  cmp_b);

  comparator_seq_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_sm(cmp_sm),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .sm(sm), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
    exp_t e;
    logic [3:0] na, nb;
    e.res = 4'b1000;
    e.lat = 5;
    for (int i = 3; i >= 0; i--) begin
      na = av[4*i +: 4];
      nb = bv[4*i +: 4];
      if (na > nb) begin e.res = 4'b0100; e.lat = 5 - i; return e; end
      if (na < nb) begin e.res = 4'b0010; e.lat = 5 - i; return e; end
    end
    return e;
  endfunction

  // Starts one compare from an IDLE cycle, records RUN nibbles, returns in the cycle after done.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input bit frc, input logic [2:0] ff, output int lat);
    exp_t e;
    if (frc) begin e.res = 4'b0001; e.lat = 2; end
    else e = model(av, bv);
    sb.push_back(e);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    force_en = frc; force_flags = ff;
    pairs.delete();
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) pairs.push_back({cmp_a, cmp_b});
      tick();
      force_en = 1'b0;
    end
    force_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, eq, gt, sm, err} !== 6'b0) $display("FAIL reset_flags: got %b required 000000", {busy, done, eq, gt, sm, err});
    else passed++;
    checks++;
    if ({cmp_a, cmp_b} !== 8'h00) $display("FAIL reset_cmp: got %h required 00", {cmp_a, cmp_b});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    int lat; exp_t e;
    run_op(16'hA5A5, 16'hA5A5, 1'b0, 3'b000, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || lat !== 5) $display("FAIL eq_latency: got %0d required %0d", lat, e.lat);
    else passed++;
    checks++;
    if ({eq, gt, sm, err} !== e.res) $display("FAIL eq_result: got %b required %b", {eq, gt, sm, err}, e.res);
    else passed++;
    checks++;
    if (pairs.size() != 4) $display("FAIL eq_run_cycles: got %0d required 4", pairs.size());
    else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL eq_after_done: got busy=%b done=%b required 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_gt();
    int lat; exp_t e;
    run_op(16'hE000, 16'hA000, 1'b0, 3'b000, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || lat !== 2) $display("FAIL gt_latency: got %0d required %0d", lat, e.lat);
    else passed++;
    checks++;
    if ({eq, gt, sm, err} !== e.res) $display("FAIL gt_result: got %b required %b", {eq, gt, sm, err}, e.res);
    else passed++;
    checks++;
    if (pairs.size() != 1 || pairs[0] !== 8'hEA) $display("FAIL gt_nibble: got %0d pairs first %h required 1 pair EA", pairs.size(), (pairs.size() > 0) ? pairs[0] : 8'hxx);
    else passed++;
  endtask

  task automatic test_sm();
    int lat; exp_t e;
    logic [31:0] seen;
    run_op(16'h1234, 16'h1235, 1'b0, 3'b000, lat);
    e = sb.pop_front();
    seen = '0;
    for (int i = 0; i < pairs.size() && i < 4; i++) seen[8*(3-i) +: 8] = pairs[i];
    checks++;
    if (lat !== e.lat || lat !== 5) $display("FAIL sm_latency: got %0d required %0d", lat, e.lat);
    else passed++;
    checks++;
    if ({eq, gt, sm, err} !== e.res) $display("FAIL sm_result: got %b required %b", {eq, gt, sm, err}, e.res);
    else passed++;
    checks++;
    if (pairs.size() != 4 || seen !== 32'h11223345) $display("FAIL sm_nibbles: got %0d pairs %h required 4 pairs 11223345", pairs.size(), seen);
    else passed++;
  endtask

  task automatic test_busy_start();
    exp_t e;
    int lat;
    e = model(16'h00F0, 16'h0010);
    sb.push_back(e);
    a = 16'h00F0; b = 16'h0010; start = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b0;
    checks++;
    if ({cmp_a, cmp_b} !== 8'h00) $display("FAIL busy_no_recapture: got %h required 00", {cmp_a, cmp_b});
    else passed++;
    lat = -1;
    for (int c = 2; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      tick();
    end
    e = sb.pop_front();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (lat !== e.lat) $display("FAIL busy_latency: got %0d required %0d", lat, e.lat);
    else passed++;
    checks++;
    if ({eq, gt, sm, err} !== e.res) $display("FAIL busy_result: got %b required %b", {eq, gt, sm, err}, e.res);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL done_start_ignored: got busy=%b required 0", busy);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; exp_t e;
    bit seen_done;
    a = 16'hA5A5; b = 16'hA5A5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, eq, gt, sm, err} !== 6'b0 || {cmp_a, cmp_b} !== 8'h00)
      $display("FAIL mid_reset: got flags %b cmp %h required 000000 00", {busy, done, eq, gt, sm, err}, {cmp_a, cmp_b});
    else passed++;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done) $display("FAIL mid_reset_quiet: got activity=1 required 0");
    else passed++;
    run_op(16'hE000, 16'hA000, 1'b0, 3'b000, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || {eq, gt, sm, err} !== e.res)
      $display("FAIL mid_reset_restart: got lat=%0d res=%b required lat=%0d res=%b", lat, {eq, gt, sm, err}, e.lat, e.res);
    else passed++;
  endtask

  task automatic test_err();
    int lat; exp_t e;
    logic [2:0] bad[2];
    bad[0] = 3'b000;
    bad[1] = 3'b110;
    for (int i = 0; i < 2; i++) begin
      run_op(16'h1234, 16'h1234, 1'b1, bad[i], lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || {eq, gt, sm, err} !== e.res)
        $display("FAIL err_%b: got lat=%0d res=%b required lat=%0d res=%b", bad[i], lat, {eq, gt, sm, err}, e.lat, e.res);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat; exp_t e;
    logic [15:0] av, bv;
    for (int i = 0; i < 16; i++) begin
      av = 16'($urandom);
      case (i % 3)
        0: bv = av;
        1: bv = av ^ (16'(1) << $urandom_range(0, 15));
        default: bv = 16'($urandom);
      endcase
      run_op(av, bv, 1'b0, 3'b000, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || {eq, gt, sm, err} !== e.res)
        $display("FAIL b2b_%0d a=%h b=%h: got lat=%0d res=%b required lat=%0d res=%b", i, av, bv, lat, {eq, gt, sm, err}, e.lat, e.res);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt();
    test_sm();
    test_busy_start();
    test_reset_mid();
    test_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
